// File: rtl/bird_physics.sv
// Vertical physics and game-state control for a flappy-style bird, stepped once per video frame.
// Position and velocity are fixed-point with FRAC fraction bits; BirdY is the integer part of the position.
module bird_physics #(
  parameter int          X_POS     = 160,
  parameter int          Y_START   = 240,
  parameter int          SIZE      = 4,
  parameter int          Y_MIN     = 0,
  parameter int          Y_MAX     = 479,
  parameter int          FRAC      = 2,
  parameter int          GRAVITY   = 1,
  parameter int          FLAP_VEL  = 16,
  parameter int          VMAX_FALL = 24,
  parameter logic [7:0]  FLAP_KEY  = 8'h44
) (
  input  logic              frame_clk,
  input  logic              Reset,
  input  logic [7:0]        keycode,
  input  logic              collide,
  output logic [9:0]        BirdX,
  output logic [9:0]        BirdY,
  output logic [9:0]        BirdS,
  output logic signed [7:0] Bird_Vy,
  output logic [1:0]        game_state,
  output logic              game_over
);

  localparam int PW = 10 + FRAC;
  localparam int CW = PW + 2;

  localparam logic [PW-1:0]        POS_START = PW'(Y_START << FRAC);
  localparam logic [PW-1:0]        POS_LAUNCH = PW'((Y_START << FRAC) - FLAP_VEL);
  localparam logic [PW-1:0]        POS_TOP   = PW'((Y_MIN + SIZE) << FRAC);
  localparam logic [PW-1:0]        POS_BOT   = PW'((Y_MAX - SIZE) << FRAC);
  localparam logic signed [CW-1:0] TOP_LIM   = CW'(Y_MIN + SIZE);
  localparam logic signed [CW-1:0] BOT_LIM   = CW'(Y_MAX - SIZE);
  localparam logic signed [7:0]    VEL_FLAP  = 8'(-FLAP_VEL);
  localparam logic signed [9:0]    VMAX_W    = 10'(VMAX_FALL);
  localparam logic signed [9:0]    GRAV_W    = 10'(GRAVITY);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_FLY  = 2'b01,
    S_DEAD = 2'b10
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        pos_q, pos_d;
  logic signed [7:0]    vel_q, vel_d;
  logic                 key_prev_q, key_prev_d;
  logic                 game_over_q, game_over_d;

  logic                 key_now;
  logic                 flap_edge;
  logic signed [7:0]    vel_new;
  logic signed [CW-1:0] cand;
  logic signed [CW-1:0] cand_px;
  logic                 top_hit;
  logic                 bot_hit;

  // Gravity step with saturation at the terminal fall speed; done wide so v+GRAVITY never wraps.
  function automatic logic signed [7:0] fall_step(input logic signed [7:0] v);
    logic signed [9:0] s;
    s = {{2{v[7]}}, v} + GRAV_W;
    if (s > VMAX_W) fall_step = VMAX_W[7:0];
    else            fall_step = s[7:0];
  endfunction

  assign key_now   = (keycode == FLAP_KEY);
  assign flap_edge = key_now & ~key_prev_q;

  always_comb begin
    vel_new = flap_edge ? VEL_FLAP : fall_step(vel_q);
    cand    = $signed({2'b00, pos_q}) + $signed({{(CW-8){vel_new[7]}}, vel_new});
    cand_px = cand >>> FRAC;
    top_hit = (cand_px <= TOP_LIM);
    bot_hit = (cand_px >= BOT_LIM);
  end

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    vel_d      = vel_q;
    key_prev_d = key_now;
    unique case (state_q)
      S_IDLE: begin
        pos_d = POS_START;
        vel_d = '0;
        if (flap_edge) begin
          state_d = S_FLY;
          pos_d   = POS_LAUNCH;
          vel_d   = VEL_FLAP;
        end
      end
      S_FLY: begin
        // Collision wins over everything; a boundary hit wins over the flap that caused it.
        if (collide) begin
          state_d = S_DEAD;
          vel_d   = '0;
        end else if (top_hit) begin
          state_d = S_DEAD;
          pos_d   = POS_TOP;
          vel_d   = '0;
        end else if (bot_hit) begin
          state_d = S_DEAD;
          pos_d   = POS_BOT;
          vel_d   = '0;
        end else begin
          pos_d = cand[PW-1:0];
          vel_d = vel_new;
        end
      end
      S_DEAD: begin
        if (flap_edge) begin
          state_d = S_IDLE;
          pos_d   = POS_START;
          vel_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        pos_d   = POS_START;
        vel_d   = '0;
      end
    endcase
    game_over_d = (state_d == S_DEAD);
  end

  // key_prev resets high so a key held through reset cannot launch the bird.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      pos_q       <= POS_START;
      vel_q       <= '0;
      key_prev_q  <= 1'b1;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      vel_q       <= vel_d;
      key_prev_q  <= key_prev_d;
      game_over_q <= game_over_d;
    end
  end

  assign BirdX      = 10'(X_POS);
  assign BirdS      = 10'(SIZE);
  assign BirdY      = pos_q[FRAC+9:FRAC];
  assign Bird_Vy    = vel_q;
  assign game_state = state_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_bird_physics.sv
// Directed bench for bird_physics with default parameters: launch, fall, held key, collide, top clamp, reset.
module tb_bird_physics;

  logic              frame_clk = 1'b0;
  logic              Reset;
  logic [7:0]        keycode;
  logic              collide;
  logic [9:0]        BirdX, BirdY, BirdS;
  logic signed [7:0] Bird_Vy;
  logic [1:0]        game_state;
  logic              game_over;

  int n_checks = 0;
  int n_errors = 0;

  bird_physics dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .collide    (collide),
    .BirdX      (BirdX),
    .BirdY      (BirdY),
    .BirdS      (BirdS),
    .Bird_Vy    (Bird_Vy),
    .game_state (game_state),
    .game_over  (game_over)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  initial begin
    int prev_vy;
    int max_vy;
    int held_y;

    Reset   = 1'b1;
    keycode = 8'h00;
    collide = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    check("rst_x", BirdX, 160);
    check("rst_y", BirdY, 240);
    check("rst_s", BirdS, 4);
    check("rst_vy", Bird_Vy, 0);
    check("rst_state", game_state, 0);
    check("rst_over", game_over, 0);

    // Collide is ignored while idle.
    collide = 1'b1;
    tick();
    collide = 1'b0;
    check("idle_collide_state", game_state, 0);
    check("idle_collide_y", BirdY, 240);

    keycode = 8'h44;
    tick();
    check("launch_state", game_state, 1);
    check("launch_vy", Bird_Vy, -16);
    check("launch_y", BirdY, 236);
    keycode = 8'h00;
    tick();
    check("launch2_vy", Bird_Vy, -15);
    check("launch2_y", BirdY, 232);

    // Free fall to the floor.
    prev_vy = -15;
    max_vy  = -15;
    for (int i = 0; i < 300 && game_state == 2'b01; i++) begin
      tick();
      if (game_state == 2'b01) begin
        check("fall_vy", Bird_Vy, (prev_vy + 1 > 24) ? 24 : prev_vy + 1);
        prev_vy = Bird_Vy;
        if (prev_vy > max_vy) max_vy = prev_vy;
      end
    end
    check("fall_max_vy", max_vy, 24);
    check("floor_state", game_state, 2);
    check("floor_y", BirdY, 475);
    check("floor_vy", Bird_Vy, 0);
    check("floor_over", game_over, 1);

    keycode = 8'h44;
    tick();
    check("dead_to_idle_state", game_state, 0);
    check("dead_to_idle_y", BirdY, 240);
    check("dead_to_idle_over", game_over, 0);
    keycode = 8'h00;
    tick();

    // Held key: exactly one flap, then gravity each frame.
    keycode = 8'h44;
    tick();
    check("hold_start_vy", Bird_Vy, -16);
    prev_vy = -16;
    for (int i = 0; i < 19; i++) begin
      tick();
      check("hold_vy", Bird_Vy, prev_vy + 1);
      prev_vy = Bird_Vy;
    end
    check("hold_end_vy", Bird_Vy, 3);
    keycode = 8'h00;
    tick();
    check("release_vy", Bird_Vy, 4);
    keycode = 8'h44;
    tick();
    check("reflap_vy", Bird_Vy, -16);

    // Collide together with a flap edge.
    keycode = 8'h00;
    tick();
    check("pre_collide_vy", Bird_Vy, -15);
    held_y  = BirdY;
    keycode = 8'h44;
    collide = 1'b1;
    tick();
    collide = 1'b0;
    check("collide_state", game_state, 2);
    check("collide_y", BirdY, held_y);
    check("collide_vy", Bird_Vy, 0);
    check("collide_over", game_over, 1);
    tick();
    check("dead_held_key_state", game_state, 2);
    collide = 1'b1;
    tick();
    collide = 1'b0;
    check("dead_collide_state", game_state, 2);
    check("dead_collide_y", BirdY, held_y);
    keycode = 8'h00;
    tick();
    keycode = 8'h44;
    tick();
    check("restart_state", game_state, 0);
    check("restart_y", BirdY, 240);

    // Repeated flaps up to the ceiling.
    keycode = 8'h00;
    tick();
    for (int i = 0; i < 300 && game_state != 2'b10; i++) begin
      keycode = (i % 2 == 0) ? 8'h44 : 8'h00;
      tick();
    end
    check("ceiling_state", game_state, 2);
    check("ceiling_y", BirdY, 4);
    check("ceiling_vy", Bird_Vy, 0);
    check("ceiling_over", game_over, 1);

    // Reset with the flap key held.
    keycode = 8'h44;
    Reset   = 1'b1;
    tick();
    Reset = 1'b0;
    check("rst_held_state", game_state, 0);
    check("rst_held_y", BirdY, 240);
    check("rst_held_vy", Bird_Vy, 0);
    check("rst_held_over", game_over, 0);
    tick();
    check("rst_held_noflap1", game_state, 0);
    tick();
    check("rst_held_noflap2", game_state, 0);
    keycode = 8'h00;
    tick();
    keycode = 8'h44;
    tick();
    check("rst_repress_state", game_state, 1);
    check("rst_repress_vy", Bird_Vy, -16);
    check("rst_repress_y", BirdY, 236);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
